// File: rtl/jpeg_pkg.sv
// Shared constants and FSM state type for the JPEG block scheduler.
// The scheduler reads 8x8 blocks from SRAM A and writes RLC results to SRAM B.
package jpeg_pkg;

    localparam int N_BLK        = 1728;
    localparam int BLK_PER_CH   = 576;
    localparam int ADDR_W       = 11;
    localparam int RLC_W        = 99;
    localparam int MAX_INFLIGHT = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } sched_state_e;

endpackage

// File: rtl/jpeg_addr_fifo.sv
// Synchronous FIFO that holds the SRAM A addresses of blocks still in the datapath.
// The head entry is visible on rdata without a read cycle.
module jpeg_addr_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 11,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: storage has no reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/jpeg_blk_sched.sv
// Frame scheduler: issues SRAM A block reads under a credit limit and writes
// each RLC result back to SRAM B at the address its block was read from.
module jpeg_blk_sched
    import jpeg_pkg::*;
#(
    parameter int N_BLK        = jpeg_pkg::N_BLK,
    parameter int MAX_INFLIGHT = jpeg_pkg::MAX_INFLIGHT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              mode,
    input  logic              pipe_ready,
    output logic [ADDR_W-1:0] sramA_raddr,
    output logic              rd_issue,
    output logic              blk_valid,
    output logic [1:0]        blk_ch,
    input  logic              res_valid,
    input  logic [RLC_W-1:0]  res_data,
    output logic [ADDR_W-1:0] sramB_waddr,
    output logic [RLC_W-1:0]  sramB_wdata,
    output logic              sramB_wen,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(N_BLK + 1);
    localparam int K_W   = $clog2(BLK_PER_CH);
    localparam int OCC_W = $clog2(MAX_INFLIGHT + 1);

    sched_state_e      state_q, state_d;
    logic              mode_q;
    logic [CNT_W-1:0]  issue_cnt_q, write_cnt_q;
    logic [K_W-1:0]    k_q;
    logic [1:0]        ch_q;
    logic              start, pop;
    logic              fifo_full, fifo_empty;
    logic [ADDR_W-1:0] fifo_rdata;
    logic [OCC_W-1:0]  inflight;

    assign start    = (state_q == S_IDLE) && enable;
    assign rd_issue = (state_q == S_RUN) && pipe_ready && !fifo_full;
    assign pop      = res_valid && !fifo_empty;
    assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);

    jpeg_addr_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (ADDR_W)
    ) u_addr_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (start),
        .push  (rd_issue),
        .pop   (pop),
        .wdata (sramA_raddr),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (inflight)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (enable) state_d = S_RUN;
            S_RUN:   if (rd_issue && issue_cnt_q == CNT_W'(N_BLK - 1)) state_d = S_DRAIN;
            S_DRAIN: if (inflight == '0 && write_cnt_q == CNT_W'(N_BLK)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Mode 0 walks one channel at a time (stride 3), then restarts at the next channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sramA_raddr <= '0;
            issue_cnt_q <= '0;
            k_q         <= '0;
            ch_q        <= '0;
            mode_q      <= 1'b0;
        end else if (start) begin
            sramA_raddr <= '0;
            issue_cnt_q <= '0;
            k_q         <= '0;
            ch_q        <= '0;
            mode_q      <= mode;
        end else if (rd_issue) begin
            issue_cnt_q <= issue_cnt_q + CNT_W'(1);
            if (mode_q) begin
                sramA_raddr <= sramA_raddr + ADDR_W'(1);
            end else if (k_q == K_W'(BLK_PER_CH - 1)) begin
                k_q         <= '0;
                ch_q        <= ch_q + 2'd1;
                sramA_raddr <= ADDR_W'(ch_q + 2'd1);
            end else begin
                k_q         <= k_q + K_W'(1);
                sramA_raddr <= sramA_raddr + ADDR_W'(3);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_valid <= 1'b0;
            blk_ch    <= '0;
        end else begin
            blk_valid <= rd_issue;
            if (rd_issue) blk_ch <= ch_q;
        end
    end

    // A result with nothing outstanding is a protocol error, never a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_cnt_q <= '0;
            err         <= 1'b0;
            sramB_wen   <= 1'b1;
            sramB_waddr <= '0;
            sramB_wdata <= '0;
        end else begin
            sramB_wen <= !pop;
            if (pop) begin
                sramB_waddr <= fifo_rdata;
                sramB_wdata <= res_data;
            end
            if (start) begin
                write_cnt_q <= '0;
                err         <= 1'b0;
            end else begin
                if (pop) write_cnt_q <= write_cnt_q + CNT_W'(1);
                if (res_valid && fifo_empty) err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jpeg_blk_sched.sv
// Scoreboard bench for jpeg_blk_sched: a responder returns one result per
// issued read and the expected SRAM B write is queued when the result is driven.
module tb_jpeg_blk_sched;
    import jpeg_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              mode = 1'b0;
    logic              pipe_ready = 1'b0;
    logic              res_valid = 1'b0;
    logic [RLC_W-1:0]  res_data = '0;
    logic [ADDR_W-1:0] sramA_raddr;
    logic              rd_issue, blk_valid;
    logic [1:0]        blk_ch;
    logic [ADDR_W-1:0] sramB_waddr;
    logic [RLC_W-1:0]  sramB_wdata;
    logic              sramB_wen, busy, done, err;

    always #5 clk = ~clk;

    jpeg_blk_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .mode        (mode),
        .pipe_ready  (pipe_ready),
        .sramA_raddr (sramA_raddr),
        .rd_issue    (rd_issue),
        .blk_valid   (blk_valid),
        .blk_ch      (blk_ch),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .sramB_waddr (sramB_waddr),
        .sramB_wdata (sramB_wdata),
        .sramB_wen   (sramB_wen),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [RLC_W-1:0]  data;
    } wr_t;

    wr_t sb_q[$];

    function automatic int exp_addr(input logic m, input int idx);
        return m ? idx : (idx % BLK_PER_CH) * 3 + idx / BLK_PER_CH;
    endfunction

    function automatic int exp_ch(input logic m, input int idx);
        return m ? 0 : idx / BLK_PER_CH;
    endfunction

    logic             mode_cur = 1'b0;
    logic             resp_en = 1'b1;
    logic             man_rv = 1'b0;
    logic             man_expect = 1'b0;
    logic [RLC_W-1:0] man_data = '0;
    int               iss_idx = 0, blk_idx = 0, push_idx = 0, wr_seen = 0;
    int               done_cnt = 0, frame_iss = 0, frame_wr = 0;
    logic             issued_flag = 1'b0, prev_issue = 1'b0, prev_done = 1'b0;
    logic [2:0]       pipe = '0;

    // Monitor: outputs are sampled mid-cycle, after inputs have settled.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n) begin
            issued_flag = rd_issue;
            if (rd_issue) begin
                check("raddr", sramA_raddr, exp_addr(mode_cur, iss_idx));
                iss_idx++;
            end
            check("blk_valid", blk_valid, prev_issue);
            if (blk_valid) begin
                check("blk_ch", blk_ch, exp_ch(mode_cur, blk_idx));
                blk_idx++;
            end
            prev_issue = rd_issue;
            if (sramB_wen === 1'b0) begin
                wr_seen++;
                check("write_expected", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("waddr", sramB_waddr, e.addr);
                    check("wdata", sramB_wdata, e.data);
                end
            end
            if (done) begin
                check("done_width", prev_done, 0);
                done_cnt++;
                frame_iss = iss_idx;
                frame_wr  = wr_seen;
                iss_idx   = 0;
                blk_idx   = 0;
                wr_seen   = 0;
                push_idx  = 0;
            end
            prev_done = done;
        end else begin
            issued_flag = 1'b0;
            prev_issue  = 1'b0;
            prev_done   = 1'b0;
        end
    end

    // Responder: a result about three cycles after each issued read.
    always @(posedge clk) begin
        logic [127:0] rnd;
        #1;
        if (!rst_n) begin
            pipe      = '0;
            res_valid = 1'b0;
        end else begin
            res_valid = 1'b0;
            if (pipe[2]) begin
                rnd       = {$urandom(), $urandom(), $urandom(), $urandom()};
                res_valid = 1'b1;
                res_data  = rnd[RLC_W-1:0];
                sb_q.push_back('{addr: ADDR_W'(exp_addr(mode_cur, push_idx)), data: res_data});
                push_idx++;
            end else if (man_rv) begin
                res_valid = 1'b1;
                res_data  = man_data;
                if (man_expect) begin
                    sb_q.push_back('{addr: ADDR_W'(exp_addr(mode_cur, push_idx)), data: res_data});
                    push_idx++;
                end
            end
            pipe = {pipe[1:0], issued_flag && resp_en};
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_raddr"}, sramA_raddr, 0);
        check({tag, "_rd_issue"}, rd_issue, 0);
        check({tag, "_blk_valid"}, blk_valid, 0);
        check({tag, "_blk_ch"}, blk_ch, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_wen"}, sramB_wen, 1);
        check({tag, "_waddr"}, sramB_waddr, 0);
        check({tag, "_wdata"}, sramB_wdata, 0);
    endtask

    task automatic wait_done(input int target, input int budget, input bit rnd_ready);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            if (rnd_ready) pipe_ready = ($urandom_range(0, 3) != 0);
            cyc(1);
            n++;
        end
        pipe_ready = 1'b1;
        check("done_seen", done_cnt >= target, 1);
    endtask

    task automatic frame_checks(input int target);
        check("frame_issues", frame_iss, N_BLK);
        check("frame_writes", frame_wr, N_BLK);
        check("sb_drained", sb_q.size(), 0);
        check("done_count", done_cnt, target);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        cyc(2);

        // Result with nothing outstanding while idle.
        man_data = 99'h1234;
        man_expect = 1'b0;
        man_rv = 1'b1;
        cyc(1);
        man_rv = 1'b0;
        cyc(2);
        check("idle_err", err, 1);
        check("idle_wen", sramB_wen, 1);
        check("idle_wr_seen", wr_seen, 0);

        // Frame A: sequential order, enable dropped mid-run.
        mode_cur = 1'b1;
        mode = 1'b1;
        pipe_ready = 1'b1;
        enable = 1'b1;
        cyc(1);
        check("a_busy", busy, 1);
        check("a_err_cleared", err, 0);
        cyc(100);
        enable = 1'b0;
        wait_done(1, 5000, 1'b0);
        frame_checks(1);
        cyc(2);
        check("a_idle", busy, 0);

        // Frame B: channel-major order with a throttled pipeline.
        mode_cur = 1'b0;
        mode = 1'b0;
        enable = 1'b1;
        cyc(1);
        enable = 1'b0;
        wait_done(2, 8000, 1'b1);
        frame_checks(2);

        // Frame C: reset after 100 issues, enable kept high throughout.
        mode_cur = 1'b1;
        mode = 1'b1;
        enable = 1'b1;
        n = 0;
        while (iss_idx < 100 && n < 500) begin
            cyc(1);
            n++;
        end
        check("c_reached_100", iss_idx >= 100, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sb_q.delete();
        iss_idx = 0;
        blk_idx = 0;
        wr_seen = 0;
        push_idx = 0;
        cyc(3);
        rst_n = 1'b1;

        // Frame D restarts from address 0; frame E follows without a new request.
        wait_done(3, 5000, 1'b0);
        frame_checks(3);
        cyc(3);
        check("e_autostart", busy, 1);
        enable = 1'b0;
        wait_done(4, 5000, 1'b0);
        frame_checks(4);
        cyc(2);

        // Frame F: no results, so the credit limit stalls reads.
        resp_en = 1'b0;
        enable = 1'b1;
        cyc(1);
        enable = 1'b0;
        cyc(20);
        check("bp_issues", iss_idx, MAX_INFLIGHT);
        check("bp_rd_issue", rd_issue, 0);
        check("bp_busy", busy, 1);
        man_data = {3'b101, 96'hDEAD_BEEF_0123_4567_89AB_CDEF};
        man_expect = 1'b1;
        man_rv = 1'b1;
        cyc(1);
        man_rv = 1'b0;
        man_expect = 1'b0;
        cyc(3);
        check("bp_one_write", wr_seen, 1);
        check("bp_next_issue", iss_idx, MAX_INFLIGHT + 1);
        check("bp_sb_empty", sb_q.size(), 0);
        check("bp_err", err, 0);

        rst_n = 1'b0;
        #1;
        check("final_reset_wen", sramB_wen, 1);
        check("final_reset_busy", busy, 0);
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
